// File: rtl/pwm_pkg.sv
// Shared constants for the PWM capture block and its stimulus generator:
// FSM encoding, default counter width and the generator's period resolution.
package pwm_pkg;

    // Generator produces periods of 2^GEN_BITS cycles; capture needs one extra bit.
    localparam int GEN_BITS      = 16;
    localparam int PWM_WIDTH_DEF = GEN_BITS + 1;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int ARM_CYCLES = 5;
`else
    localparam int ARM_CYCLES = 3;
`endif

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2,
        STALL     = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// Synchronises pwm_in, optionally glitch-filters it (macro PWM_CAPTURE_FILTER_EN),
// and produces the registered level s plus single-cycle rise/fall strobes.
module pwm_edge_detect
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_s;
    logic       r_s_prev;
    logic       r_seen_low;
    logic [2:0] r_arm_cnt;
    logic       w_level;
    logic       w_armed;

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_hold;

    // Level only moves once three consecutive synchronised samples agree.
    assign w_level = (r_sync2 == r_hist[0] && r_sync2 == r_hist[1]) ? r_sync2 : r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b00;
            r_hold <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            r_hold <= w_level;
        end
    end
`else
    assign w_level = r_sync2;
`endif

    assign w_armed = (r_arm_cnt == 3'(ARM_CYCLES));

    // A rise counts only after s has been low on real pin samples, so a pin
    // already high at reset release is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_s        <= 1'b0;
            r_s_prev   <= 1'b0;
            r_seen_low <= 1'b0;
            r_arm_cnt  <= 3'd0;
        end else begin
            r_sync1    <= i_pwm;
            r_sync2    <= r_sync1;
            r_s        <= w_level;
            r_s_prev   <= r_s;
            r_seen_low <= r_seen_low | (w_armed & ~r_s);
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    assign o_s    = r_s;
    assign o_rise = r_s & ~r_s_prev & r_seen_low;
    assign o_fall = ~r_s & r_s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles.
// Glitch filtering is enabled by defining PWM_CAPTURE_FILTER_EN.
//
// state     | meaning
// WAIT_RISE | idle after reset, first partial period is discarded
// HIGH      | counting high time and period
// LOW       | counting period, next rise publishes
// STALL     | no rise within 2^WIDTH-1 cycles, waiting for a rise
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] period_count,
    output logic             valid,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    pwm_state_t       r_state;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_high_count;
    logic [WIDTH-1:0] r_period_count;
    logic             r_valid;
    logic             r_stalled;
    logic             w_s;
    logic             w_rise;
    logic             w_fall;

    pwm_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_pwm  (pwm_in),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= WAIT_RISE;
            r_hcnt         <= '0;
            r_pcnt         <= '0;
            r_high_count   <= '0;
            r_period_count <= '0;
            r_valid        <= 1'b0;
            r_stalled      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_hcnt  <= C_ONE;
                        r_pcnt  <= C_ONE;
                    end
                end
                HIGH: begin
                    if (r_pcnt == C_MAX) begin
                        r_state   <= STALL;
                        r_stalled <= 1'b1;
                    end else begin
                        r_pcnt <= r_pcnt + C_ONE;
                        if (w_s) begin
                            r_hcnt <= r_hcnt + C_ONE;
                        end
                        if (w_fall) begin
                            r_state <= LOW;
                        end
                    end
                end
                LOW: begin
                    // Saturation takes priority over a coincident rise.
                    if (r_pcnt == C_MAX) begin
                        r_state   <= STALL;
                        r_stalled <= 1'b1;
                    end else if (w_rise) begin
                        r_high_count   <= r_hcnt;
                        r_period_count <= r_pcnt;
                        r_valid        <= 1'b1;
                        r_state        <= HIGH;
                        r_hcnt         <= C_ONE;
                        r_pcnt         <= C_ONE;
                    end else begin
                        r_pcnt <= r_pcnt + C_ONE;
                    end
                end
                STALL: begin
                    if (w_rise) begin
                        r_state   <= HIGH;
                        r_stalled <= 1'b0;
                        r_hcnt    <= C_ONE;
                        r_pcnt    <= C_ONE;
                    end
                end
                default: begin
                    r_state <= WAIT_RISE;
                end
            endcase
        end
    end

    assign high_count   = r_high_count;
    assign period_count = r_period_count;
    assign valid        = r_valid;
    assign stalled      = r_stalled;

endmodule
